// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared NRISC constants, ULA opcodes and multiplier sequencer state type.
package nrisc_pkg;
    localparam int TAM_DEFAULT = 16;

    localparam logic [3:0] ULA_ADD = 4'b0000;
    localparam logic [3:0] ULA_SUB = 4'b0001;
    localparam logic [3:0] ULA_SHR = 4'b0101;
    localparam logic [3:0] ULA_SHL = 4'b0110;

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mul_state_t;
endpackage

// File: rtl/nrisc_mul_seq.sv
// nrisc_mul_seq: shift-and-add multiplier that borrows the shared ULA, bypassing ex_* when idle.
module nrisc_mul_seq
    import nrisc_pkg::*;
#(
    parameter int TAM = TAM_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [TAM-1:0] op_a,
    input  logic [TAM-1:0] op_b,
    output logic           busy,
    output logic           done,
    output logic [TAM-1:0] result,
    input  logic [TAM-1:0] ex_a,
    input  logic [TAM-1:0] ex_b,
    input  logic [3:0]     ex_ctrl,
    output logic           ex_stall,
    output logic [TAM-1:0] ula_a,
    output logic [TAM-1:0] ula_b,
    output logic [3:0]     ula_ctrl,
    input  logic [TAM-1:0] ula_out
);
    mul_state_t state;
    logic [TAM-1:0] m, q, p;

    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign ex_stall = busy;

    always_comb begin
        ula_a    = state == ADD ? p : state == SHIFT ? m : ex_a;
        ula_b    = state == ADD ? m : state == SHIFT ? '0 : ex_b;
        ula_ctrl = state == ADD ? ULA_ADD : state == SHIFT ? ULA_SHL : ex_ctrl;
    end

    // q is nonzero in SHIFT, so the loop always reaches an ADD that can finish
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            m      <= '0;
            q      <= '0;
            p      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    m     <= op_a;
                    q     <= op_b;
                    p     <= '0;
                    state <= op_b == '0 ? DONE : op_b[0] ? ADD : SHIFT;
                end
                ADD: begin
                    p     <= ula_out;
                    state <= q[TAM-1:1] == '0 ? DONE : SHIFT;
                end
                SHIFT: begin
                    m     <= ula_out;
                    q     <= q >> 1;
                    state <= q[1] ? ADD : SHIFT;
                end
                DONE: begin
                    result <= p;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nrisc_mul_seq.sv
// tb_nrisc_mul_seq: randomized check of the multiplier against a product/latency reference model.
module tb_nrisc_mul_seq;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [15:0] op_a = 0, op_b = 0;
    logic        busy, done, ex_stall;
    logic [15:0] result;
    logic [15:0] ex_a = 0, ex_b = 0;
    logic [3:0]  ex_ctrl = 0;
    logic [15:0] ula_a, ula_b, ula_out;
    logic [3:0]  ula_ctrl;
    int n_checks = 0, n_errors = 0;
    logic [15:0] ctrl_log;

    always #5 clk = ~clk;

    nrisc_mul_seq #(.TAM(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .ex_a(ex_a), .ex_b(ex_b), .ex_ctrl(ex_ctrl), .ex_stall(ex_stall),
        .ula_a(ula_a), .ula_b(ula_b), .ula_ctrl(ula_ctrl), .ula_out(ula_out)
    );

    // Behavioural ULA: add, subtract, shift left by one, else pass A
    always_comb
        ula_out = ula_ctrl == 4'b0000 ? ula_a + ula_b :
                  ula_ctrl == 4'b0001 ? ula_a - ula_b :
                  ula_ctrl == 4'b0110 ? ula_a << 1 : ula_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_latency(input logic [15:0] b);
        int hi = 0;
        if (b == 0) return 1;
        for (int i = 0; i < 16; i++) if (b[i]) hi = i;
        return 1 + $countones(b) + hi;
    endfunction

    // Called just after a negedge; returns at the negedge of the IDLE cycle after done.
    task automatic mul(input string tag, input logic [15:0] a, input logic [15:0] b, input bit hold);
        int dc = 0;
        logic [15:0] exp_res = 16'(32'(a) * 32'(b));
        start = 1; op_a = a; op_b = b; ctrl_log = 0;
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            @(negedge clk);
            if (!hold) start = 0;
            ex_a = 16'($urandom); ex_b = 16'($urandom); ex_ctrl = 4'($urandom);
            #1;
            if (busy !== 1'b1 || ex_stall !== 1'b1) check({tag, "_busy"}, {busy, ex_stall}, 2'b11);
            if (done) dc = c;
            else ctrl_log = {ctrl_log[11:0], ula_ctrl};
        end
        check({tag, "_latency"}, dc, ref_latency(b));
        @(negedge clk);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_outs", {busy, done, ex_stall}, 3'b000);
        check("rst_result", result, 0);
        rst = 0;
        @(negedge clk);
        ex_a = 16'h00F0; ex_b = 16'h0F00; ex_ctrl = 4'b0011;
        #1;
        check("bypass", {ula_a, ula_b, 12'(ula_ctrl)}, {16'h00F0, 16'h0F00, 12'h003});
        check("bypass_stall", ex_stall, 0);

        mul("m3x5", 16'h0003, 16'h0005, 0);
        check("m3x5_ctrl", ctrl_log, 16'h0660);
        mul("mffff", 16'hFFFF, 16'hFFFF, 0);
        mul("mzero", 16'h1234, 16'h0000, 0);
        mul("m7x9", 16'h0007, 16'h0009, 1);
        mul("back2back", 16'h0011, 16'h0003, 0);

        // reset mid-multiply
        start = 1; op_a = 16'hFFFF; op_b = 16'h00FF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 0;
            check("abort_nodone", done, 0);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_state", {busy, done, ex_stall}, 3'b000);
        check("abort_result", result, 0);
        mul("m2x8000", 16'h0002, 16'h8000, 0);

        for (int i = 0; i < 1000; i++)
            mul("rand", 16'($urandom), 16'(16'($urandom) >> $urandom_range(0, 16)), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
